// File: rtl/walsh_trig_gen.sv
`default_nettype none
// walsh_trig_gen: walsh switching trigger and step index generator with selectable
// source (external sync / internal period / software), arming, one-shot/continuous and holdoff.
module walsh_trig_gen #(
  parameter int WALSH_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               user_clk,
  input  logic               user_rst,
  input  logic [31:0]        sel_reg,
  input  logic               ext_sync,
  output logic               walsh_trig,
  output logic [WALSH_W-1:0] walsh_step,
  output logic               armed,
  output logic [CNT_W-1:0]   trig_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_EXT  = 2'd1;
  localparam logic [1:0] SRC_PER  = 2'd2;
  localparam logic [1:0] SRC_SW   = 2'd3;

  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [WALSH_W-1:0] STEP_ONE = WALSH_W'(1);

  logic [31:0]      sel_q;
  logic [31:0]      sel_q2;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             sw_ev;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [1:0]       src_cap;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;

  logic [1:0] sel_src;
  logic       sel_arm;
  logic       sel_cont;
  logic       step_clr;
  logic       arm_rise;
  logic       sw_rise;
  logic       ext_ev;
  logic       per_ev;
  logic       ev;
  logic       disarm;
  logic       holdoff_src;
  logic       fire;
  logic       unused_sel;

  assign sel_src  = sel_q[1:0];
  assign sel_arm  = sel_q[2];
  assign sel_cont = sel_q[4];
  assign step_clr = sel_q[5];
  assign arm_rise = sel_q[2] & ~sel_q2[2];
  assign sw_rise  = sel_q[3] & ~sel_q2[3];

  assign unused_sel = ^{sel_q[15:6], sel_q2[31:4], sel_q2[1:0]};

  // The period field is fixed at 16 bits in the control word; fit it to CNT_W.
  generate
    if (CNT_W == 16) begin : g_period_eq
      assign period = sel_q[31:16];
    end else if (CNT_W > 16) begin : g_period_wide
      assign period = {{(CNT_W-16){1'b0}}, sel_q[31:16]};
    end else begin : g_period_narrow
      logic unused_period_hi;
      assign period           = sel_q[16 +: CNT_W];
      assign unused_period_hi = ^sel_q[31:16+CNT_W];
    end
  endgenerate

  // Input capture: control word pipeline, ext_sync synchroniser, software edge.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      sel_q  <= '0;
      sel_q2 <= '0;
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      sw_ev  <= 1'b0;
    end else begin
      sel_q  <= sel_reg;
      sel_q2 <= sel_q;
      s1     <= ext_sync;
      s2     <= s1;
      s3     <= s2;
      sw_ev  <= sw_rise;
    end
  end

  assign ext_ev      = s2 & ~s3;
  assign per_ev      = (period != '0) && (cnt >= (period - CNT_ONE));
  assign disarm      = ~sel_arm | (sel_src != src_cap);
  assign holdoff_src = (src_cap == SRC_EXT) || (src_cap == SRC_SW);

  always_comb begin
    ev = 1'b0;
    case (src_cap)
      SRC_EXT: ev = ext_ev;
      SRC_PER: ev = per_ev;
      SRC_SW:  ev = sw_ev;
      default: ev = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; disarm always wins over a same-cycle event.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (arm_rise && (sel_src != SRC_NONE)) begin
          state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (disarm) begin
          state_nxt = ST_IDLE;
        end else if (ev) begin
          if (!sel_cont) begin
            state_nxt = ST_IDLE;
          end else if (holdoff_src && (period != '0)) begin
            state_nxt = ST_HOLDOFF;
          end
        end
      end
      ST_HOLDOFF: begin
        if (disarm) begin
          state_nxt = ST_IDLE;
        end else if (cnt <= CNT_ONE) begin
          state_nxt = ST_ARMED;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    fire  = 1'b0;
    armed = 1'b0;
    case (state)
      ST_ARMED: begin
        fire  = ev & ~disarm;
        armed = 1'b1;
      end
      ST_HOLDOFF: armed = 1'b1;
      default: begin
        fire  = 1'b0;
        armed = 1'b0;
      end
    endcase
  end

  // Shared counter: period phase while ARMED on src=2, remaining holdoff in HOLDOFF.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      cnt     <= '0;
      src_cap <= SRC_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (state_nxt == ST_ARMED) begin
            src_cap <= sel_src;
          end
        end
        ST_ARMED: begin
          if (state_nxt == ST_HOLDOFF) begin
            cnt <= period;
          end else if (src_cap == SRC_PER) begin
            cnt <= per_ev ? '0 : (cnt + CNT_ONE);
          end else begin
            cnt <= '0;
          end
        end
        ST_HOLDOFF: begin
          cnt <= (state_nxt == ST_HOLDOFF) ? (cnt - CNT_ONE) : '0;
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Trigger pulse and counters; step_clr overrides a same-cycle increment.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      walsh_trig <= 1'b0;
      walsh_step <= '0;
      trig_count <= '0;
    end else begin
      walsh_trig <= fire;
      if (step_clr) begin
        walsh_step <= '0;
        trig_count <= '0;
      end else if (fire) begin
        walsh_step <= walsh_step + STEP_ONE;
        trig_count <= trig_count + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_walsh_trig_gen.sv
`default_nettype none
// Bench for walsh_trig_gen: randomized scenarios scored against trigger times,
// step and count predicted arithmetically from the timing and holdoff rules.
module tb_walsh_trig_gen;
  localparam int WALSH_W = 5;
  localparam int CNT_W   = 16;

  logic               user_clk = 1'b0;
  logic               user_rst;
  logic [31:0]        sel_reg;
  logic               ext_sync;
  logic               walsh_trig;
  logic [WALSH_W-1:0] walsh_step;
  logic               armed;
  logic [CNT_W-1:0]   trig_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_tot = 0;
  int trig_q[$];
  int exp_q[$];

  walsh_trig_gen #(.WALSH_W(WALSH_W), .CNT_W(CNT_W)) dut (
    .user_clk   (user_clk),
    .user_rst   (user_rst),
    .sel_reg    (sel_reg),
    .ext_sync   (ext_sync),
    .walsh_trig (walsh_trig),
    .walsh_step (walsh_step),
    .armed      (armed),
    .trig_count (trig_count)
  );

  always #5 user_clk = ~user_clk;
  always @(posedge user_clk) cyc <= cyc + 1;
  always @(negedge user_clk) if (walsh_trig === 1'b1) trig_q.push_back(cyc);

  function automatic logic [31:0] mk(input int src, input bit arm, input bit sw,
                                     input bit cont, input bit clr, input int p);
    logic [15:0] pf;
    logic [1:0]  sf;
    pf = p[15:0];
    sf = src[1:0];
    return {pf, 10'b0, clr, cont, sw, arm, sf};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge user_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    user_rst = 1'b1;
    sel_reg  = '0;
    ext_sync = 1'b0;
    tick(3);
    user_rst = 1'b0;
    tick(1);
    exp_tot = 0;
    trig_q.delete();
  endtask

  task automatic test_reset();
    user_rst = 1'b1;
    sel_reg  = '0;
    ext_sync = 1'b0;
    tick(2);
    user_rst = 1'b0;
    trig_q.delete();
    for (int i = 0; i < 20; i++) begin
      ext_sync = 1'($urandom_range(0, 1));
      tick(1);
      checks++;
      if ({walsh_trig, armed, walsh_step, trig_count} !== 23'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d got trig=%b armed=%b step=%0d count=%0d want all 0",
                 cyc, walsh_trig, armed, walsh_step, trig_count);
      end
    end
    ext_sync = 1'b0;
    tick(3);
    checks++;
    if (trig_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_no_trig got %0d pulses want 0", trig_q.size());
    end
  endtask

  task automatic test_ext_oneshot();
    int c;
    do_reset();
    sel_reg = mk(1, 1, 0, 0, 0, 0);
    tick(3);
    checks++;
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL ext_armed got %b want 1", armed);
    end
    tick($urandom_range(0, 5));
    trig_q.delete();
    c = cyc;
    ext_sync = 1'b1;
    tick(1);
    ext_sync = 1'b0;
    tick(5);
    exp_tot = 1;
    checks++;
    if (trig_q.size() !== 1 || trig_q[0] !== c + 3) begin
      errors++;
      $display("FAIL ext_pulse got %0d pulses first at %0d want 1 at %0d",
               trig_q.size(), (trig_q.size() > 0) ? trig_q[0] : -1, c + 3);
    end
    checks++;
    if (walsh_step !== WALSH_W'(exp_tot) || trig_count !== CNT_W'(exp_tot)) begin
      errors++;
      $display("FAIL ext_counts got step=%0d count=%0d want %0d", walsh_step, trig_count, exp_tot);
    end
    checks++;
    if (armed !== 1'b0) begin
      errors++;
      $display("FAIL ext_oneshot_disarm got armed=%b want 0", armed);
    end
    ext_sync = 1'b1;
    tick(1);
    ext_sync = 1'b0;
    tick(6);
    checks++;
    if (trig_q.size() !== 1 || walsh_step !== WALSH_W'(exp_tot)) begin
      errors++;
      $display("FAIL ext_second_edge got %0d pulses step=%0d want 1 pulse step=%0d",
               trig_q.size(), walsh_step, exp_tot);
    end
  endtask

  task automatic test_period();
    int c;
    int p;
    int n;
    for (int run = 0; run < 3; run++) begin
      do_reset();
      p = (run == 0) ? 4 : $urandom_range(1, 7);
      n = (run == 0) ? 32 : $urandom_range(3, 8);
      c = cyc;
      sel_reg = mk(2, 1, 0, 1, 0, p);
      tick(2 + p * n);
      exp_q.delete();
      for (int i = 1; i <= n; i++) exp_q.push_back(c + 2 + p * i);
      exp_tot = n;
      checks++;
      if (trig_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL period_num P=%0d got %0d pulses want %0d", p, trig_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (trig_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL period_time P=%0d idx %0d got %0d want %0d", p, i, trig_q[i], exp_q[i]);
          end
        end
      end
      checks++;
      if (walsh_step !== WALSH_W'(exp_tot) || trig_count !== CNT_W'(exp_tot) || armed !== 1'b1) begin
        errors++;
        $display("FAIL period_counts P=%0d got step=%0d count=%0d armed=%b want step=%0d count=%0d armed=1",
                 p, walsh_step, trig_count, armed, exp_tot % 32, exp_tot);
      end
    end
    do_reset();
    sel_reg = mk(2, 1, 0, 1, 0, 0);
    tick(40);
    checks++;
    if (trig_q.size() !== 0 || armed !== 1'b1) begin
      errors++;
      $display("FAIL period_zero got %0d pulses armed=%b want 0 pulses armed=1", trig_q.size(), armed);
    end
  endtask

  task automatic test_holdoff();
    int c;
    int p;
    int a;
    int ks[$];
    for (int run = 0; run < 2; run++) begin
      do_reset();
      p = (run == 0) ? 10 : $urandom_range(4, 15);
      c = cyc;
      sel_reg = mk(1, 1, 0, 1, 0, p);
      tick(2);
      ks.delete();
      for (int e = 0; e < 12; e++) begin
        checks++;
        if (armed !== 1'b1) begin
          errors++;
          $display("FAIL holdoff_armed P=%0d cyc %0d got %b want 1", p, cyc, armed);
        end
        ks.push_back(cyc + 1);
        ext_sync = 1'b1;
        tick(1);
        ext_sync = 1'b0;
        tick(2);
      end
      tick(4);
      exp_q.delete();
      a = c + 2;
      foreach (ks[i]) begin
        if (ks[i] + 1 >= a) begin
          exp_q.push_back(ks[i] + 2);
          a = ks[i] + 2 + p;
        end
      end
      exp_tot = exp_q.size();
      checks++;
      if (trig_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL holdoff_num P=%0d got %0d pulses want %0d", p, trig_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (trig_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL holdoff_time P=%0d idx %0d got %0d want %0d", p, i, trig_q[i], exp_q[i]);
          end
        end
      end
      checks++;
      if (walsh_step !== WALSH_W'(exp_tot) || trig_count !== CNT_W'(exp_tot)) begin
        errors++;
        $display("FAIL holdoff_counts got step=%0d count=%0d want %0d", walsh_step, trig_count, exp_tot);
      end
    end
  endtask

  task automatic test_sw();
    int c;
    do_reset();
    sel_reg = mk(3, 1, 0, 1, 0, 0);
    tick(3);
    c = cyc;
    sel_reg = mk(3, 1, 1, 1, 0, 0);
    tick(12);
    exp_tot = 1;
    checks++;
    if (trig_q.size() !== 1 || trig_q[0] !== c + 3) begin
      errors++;
      $display("FAIL sw_pulse got %0d pulses first at %0d want 1 at %0d",
               trig_q.size(), (trig_q.size() > 0) ? trig_q[0] : -1, c + 3);
    end
    checks++;
    if (armed !== 1'b1 || walsh_step !== WALSH_W'(exp_tot)) begin
      errors++;
      $display("FAIL sw_held got armed=%b step=%0d want armed=1 step=%0d", armed, walsh_step, exp_tot);
    end
    sel_reg = mk(3, 1, 0, 1, 0, 0);
    tick(3 + $urandom_range(0, 4));
    c = cyc;
    sel_reg = mk(3, 1, 1, 1, 0, 0);
    tick(5);
    exp_tot = 2;
    checks++;
    if (trig_q.size() !== 2 || trig_q[1] !== c + 3) begin
      errors++;
      $display("FAIL sw_second got %0d pulses want 2 with last at %0d", trig_q.size(), c + 3);
    end
    sel_reg = mk(3, 1, 0, 1, 0, 0);
    tick(3);
    sel_reg = mk(3, 1, 1, 1, 0, 0);
    tick(1);
    sel_reg = mk(3, 0, 1, 1, 0, 0);
    tick(8);
    checks++;
    if (trig_q.size() !== 2 || armed !== 1'b0 || trig_count !== CNT_W'(exp_tot)) begin
      errors++;
      $display("FAIL sw_disarm_race got %0d pulses armed=%b count=%0d want 2 pulses armed=0 count=%0d",
               trig_q.size(), armed, trig_count, exp_tot);
    end
  endtask

  task automatic test_ignored();
    do_reset();
    sel_reg = mk(1, 1, 0, 1, 0, 0);
    tick(3);
    sel_reg = mk(1, 1, 1, 1, 0, 0);
    tick(6);
    checks++;
    if (trig_q.size() !== 0 || armed !== 1'b1) begin
      errors++;
      $display("FAIL sw_on_ext_src got %0d pulses armed=%b want 0 pulses armed=1", trig_q.size(), armed);
    end
    sel_reg = mk(3, 1, 1, 1, 0, 0);
    tick(4);
    checks++;
    if (armed !== 1'b0) begin
      errors++;
      $display("FAIL src_change_disarm got armed=%b want 0", armed);
    end
    ext_sync = 1'b1;
    tick(1);
    ext_sync = 1'b0;
    tick(5);
    checks++;
    if (trig_q.size() !== 0) begin
      errors++;
      $display("FAIL ext_when_idle got %0d pulses want 0", trig_q.size());
    end
    do_reset();
    sel_reg = mk(1, 1, 0, 1, 0, 0);
    tick(3);
    ext_sync = 1'b1;
    tick(1);
    sel_reg = mk(1, 0, 0, 1, 0, 0);
    tick(1);
    ext_sync = 1'b0;
    tick(5);
    checks++;
    if (trig_q.size() !== 0 || armed !== 1'b0) begin
      errors++;
      $display("FAIL ext_disarm_race got %0d pulses armed=%b want 0 pulses armed=0", trig_q.size(), armed);
    end
  endtask

  task automatic test_step_clr();
    int c;
    int p;
    int t;
    do_reset();
    p = $urandom_range(3, 6);
    c = cyc;
    t = c + 2 + 2 * p;
    sel_reg = mk(2, 1, 0, 1, 0, p);
    tick(t - 2 - c);
    checks++;
    if (walsh_step !== WALSH_W'(1) || trig_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL clr_before got step=%0d count=%0d want 1", walsh_step, trig_count);
    end
    sel_reg = mk(2, 1, 0, 1, 1, p);
    tick(1);
    sel_reg = mk(2, 1, 0, 1, 0, p);
    tick(1);
    checks++;
    if (walsh_trig !== 1'b1 || walsh_step !== '0 || trig_count !== '0) begin
      errors++;
      $display("FAIL clr_same_cycle got trig=%b step=%0d count=%0d want trig=1 step=0 count=0",
               walsh_trig, walsh_step, trig_count);
    end
    tick(p);
    checks++;
    if (walsh_trig !== 1'b1 || walsh_step !== WALSH_W'(1) || trig_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL clr_after got trig=%b step=%0d count=%0d want trig=1 step=1 count=1",
               walsh_trig, walsh_step, trig_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sel_reg = mk(1, 1, 0, 1, 0, 10);
    tick(3);
    ext_sync = 1'b1;
    tick(1);
    ext_sync = 1'b0;
    tick(5);
    checks++;
    if (armed !== 1'b1 || walsh_step !== WALSH_W'(1)) begin
      errors++;
      $display("FAIL mid_holdoff_pre got armed=%b step=%0d want armed=1 step=1", armed, walsh_step);
    end
    user_rst = 1'b1;
    sel_reg  = '0;
    tick(1);
    checks++;
    if ({walsh_trig, armed, walsh_step, trig_count} !== 23'd0) begin
      errors++;
      $display("FAIL mid_holdoff_reset got trig=%b armed=%b step=%0d count=%0d want all 0",
               walsh_trig, armed, walsh_step, trig_count);
    end
    user_rst = 1'b0;
    sel_reg = mk(1, 1, 0, 1, 0, 0);
    tick(3);
    trig_q.delete();
    ext_sync = 1'b1;
    tick(1);
    ext_sync = 1'b0;
    tick(1);
    user_rst = 1'b1;
    sel_reg  = '0;
    tick(1);
    user_rst = 1'b0;
    tick(5);
    checks++;
    if (trig_q.size() !== 0 || armed !== 1'b0 || trig_count !== '0) begin
      errors++;
      $display("FAIL pending_dropped got %0d pulses armed=%b count=%0d want 0 pulses armed=0 count=0",
               trig_q.size(), armed, trig_count);
    end
  endtask

  initial begin
    user_rst = 1'b1;
    sel_reg  = '0;
    ext_sync = 1'b0;
    test_reset();
    test_ext_oneshot();
    test_period();
    test_holdoff();
    test_sw();
    test_ignored();
    test_step_clr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
